// File: rtl/canvas_scanout_pkg.sv
// Shared constants, state encoding and address helper for the canvas scanout path.
// Grid is 32x32 cells per slot region, of which 32x24 are visible.
package canvas_scanout_pkg;

    localparam int CELL_DIM       = 5;
    localparam int COLS           = 32;
    localparam int ROWS           = 24;
    localparam int DEF_SLOT_SHIFT = 10;

    localparam int CX_W     = 5;
    localparam int CY_W     = 5;
    localparam int ADDR_W   = 15;
    localparam int COLOUR_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_DRAW = 3'd3,
        ST_NEXT = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    // Slot base is slot << shift; the cell index occupies the low ten bits.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic            slot,
                                                    input logic [CY_W-1:0] cy,
                                                    input logic [CX_W-1:0] cx,
                                                    input int              shift);
        return (ADDR_W'(slot) << shift) | ADDR_W'({cy, cx});
    endfunction

endpackage

// File: rtl/canvas_scanout_cell_pixel_walker.sv
// Walks the CELL_DIMENSION x CELL_DIMENSION pixel block of one cell, raster order.
// Latency: first pixel registered one cycle after start_i, then one pixel per step_i.
// Backpressure: none; the owner simply withholds step_i, x/y/plot then hold.
module cell_pixel_walker
    import canvas_scanout_pkg::*;
#(
    parameter int CELL_DIMENSION = CELL_DIM,
    parameter int XW             = 9,
    parameter int YW             = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            step_i,
    input  logic [CX_W-1:0] cx_i,
    input  logic [CY_W-1:0] cy_i,
    output logic [XW-1:0]   x_o,
    output logic [YW-1:0]   y_o,
    output logic            plot_o,
    output logic            last_o
);
    localparam int PW = (CELL_DIMENSION > 1) ? $clog2(CELL_DIMENSION) : 1;
    localparam logic [PW-1:0] PMAX = PW'(CELL_DIMENSION - 1);
    localparam logic [XW-1:0] CD_X = XW'(CELL_DIMENSION);
    localparam logic [YW-1:0] CD_Y = YW'(CELL_DIMENSION);

    logic [PW-1:0] px_q, px_d, py_q, py_d;
    logic [XW-1:0] x_q, x_d, x_base;
    logic [YW-1:0] y_q, y_d;
    logic          plot_q, plot_d;

    assign x_base = XW'(cx_i) * CD_X;
    assign last_o = plot_q && (px_q == PMAX) && (py_q == PMAX);

    always_comb begin
        px_d   = px_q;
        py_d   = py_q;
        x_d    = x_q;
        y_d    = y_q;
        plot_d = plot_q;
        if (start_i) begin
            px_d   = '0;
            py_d   = '0;
            x_d    = x_base;
            y_d    = YW'(cy_i) * CD_Y;
            plot_d = 1'b1;
        end else if (step_i && plot_q) begin
            // On the last pixel only the strobe drops; x/y keep the final coordinate.
            if (last_o) begin
                plot_d = 1'b0;
            end else if (px_q == PMAX) begin
                px_d = '0;
                py_d = py_q + 1'b1;
                x_d  = x_base;
                y_d  = y_q + 1'b1;
            end else begin
                px_d = px_q + 1'b1;
                x_d  = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            px_q   <= '0;
            py_q   <= '0;
            x_q    <= '0;
            y_q    <= '0;
            plot_q <= 1'b0;
        end else begin
            px_q   <= px_d;
            py_q   <= py_d;
            x_q    <= x_d;
            y_q    <= y_d;
            plot_q <= plot_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign plot_o = plot_q;

endmodule

// File: rtl/canvas_scanout.sv
// Replays a stored slot from canvas memory to the VGA adapter as 5x5 cell plots.
// Latency: 3 + RAM_LATENCY-1 + 25 cycles per cell; oDone after the last cell.
// Backpressure: none; iStart is ignored while busy. SCANOUT_SKIP_BLANK_EN skips black cells.
module canvas_scanout
    import canvas_scanout_pkg::*;
#(
    parameter int SCREEN_WIDTH   = 160,
    parameter int SCREEN_HEIGHT  = 120,
    parameter int CELL_DIMENSION = CELL_DIM,
    parameter int RAM_LATENCY    = 1,
    parameter int SLOT_SHIFT     = DEF_SLOT_SHIFT
) (
    input  logic                             iClk,
    input  logic                             iResetn,
    input  logic                             iStart,
    input  logic                             iSlot,
    input  logic [COLOUR_W-1:0]              iQ,
    output logic [ADDR_W-1:0]                oAddress,
    output logic                             oChipSelect,
    output logic                             oWren,
    output logic [COLOUR_W-1:0]              oColour,
    output logic [$clog2(SCREEN_WIDTH):0]    oX_pixel,
    output logic [$clog2(SCREEN_HEIGHT):0]   oY_pixel,
    output logic                             oPlot,
    output logic                             oBusy,
    output logic                             oDone
);
    localparam int XW = $clog2(SCREEN_WIDTH) + 1;
    localparam int YW = $clog2(SCREEN_HEIGHT) + 1;
    localparam logic [1:0]      WAIT_INIT = 2'(RAM_LATENCY - 1);
    localparam logic [CX_W-1:0] CX_LAST   = CX_W'(COLS - 1);
    localparam logic [CY_W-1:0] CY_LAST   = CY_W'(ROWS - 1);

    state_e              state_q, state_d;
    logic                slot_q, slot_d;
    logic [CX_W-1:0]     cx_q, cx_d;
    logic [CY_W-1:0]     cy_q, cy_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic [1:0]          wait_q, wait_d;
    logic                walk_start, walk_last, walk_plot;

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        colour_d   = colour_q;
        wait_d     = wait_q;
        walk_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    slot_d  = iSlot;
                    cx_d    = '0;
                    cy_d    = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                wait_d  = WAIT_INIT;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - 1'b1;
                end else begin
                    colour_d = iQ;
`ifdef SCANOUT_SKIP_BLANK_EN
                    if (iQ == '0) begin
                        state_d = ST_NEXT;
                    end else begin
                        walk_start = 1'b1;
                        state_d    = ST_DRAW;
                    end
`else
                    walk_start = 1'b1;
                    state_d    = ST_DRAW;
`endif
                end
            end
            ST_DRAW: begin
                if (walk_last) state_d = ST_NEXT;
            end
            ST_NEXT: begin
                // cx/cy are left on the final cell so the last address stays visible.
                if (cx_q == CX_LAST) begin
                    if (cy_q == CY_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        cx_d    = '0;
                        cy_d    = cy_q + 1'b1;
                        state_d = ST_REQ;
                    end
                end else begin
                    cx_d    = cx_q + 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iResetn) begin
        if (!iResetn) begin
            state_q  <= ST_IDLE;
            slot_q   <= 1'b0;
            cx_q     <= '0;
            cy_q     <= '0;
            colour_q <= '0;
            wait_q   <= '0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            colour_q <= colour_d;
            wait_q   <= wait_d;
        end
    end

    cell_pixel_walker #(
        .CELL_DIMENSION(CELL_DIMENSION),
        .XW            (XW),
        .YW            (YW)
    ) u_walker (
        .clk_i  (iClk),
        .rst_ni (iResetn),
        .start_i(walk_start),
        .step_i (state_q == ST_DRAW),
        .cx_i   (cx_q),
        .cy_i   (cy_q),
        .x_o    (oX_pixel),
        .y_o    (oY_pixel),
        .plot_o (walk_plot),
        .last_o (walk_last)
    );

    assign oAddress    = cell_addr(slot_q, cy_q, cx_q, SLOT_SHIFT);
    assign oChipSelect = (state_q == ST_REQ);
    assign oWren       = 1'b0;
    assign oColour     = colour_q;
    assign oPlot       = walk_plot;
    assign oBusy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign oDone       = (state_q == ST_DONE);

endmodule

// File: tb/tb_canvas_scanout.sv
// Bench for canvas_scanout: two instances (RAM latency 1 and 2) sharing one memory image.
module tb_canvas_scanout;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic st1 = 1'b0, st2 = 1'b0, slot_in = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  q1, q2, c1, c2;
    logic [14:0] a1, a2;
    logic        cs1, cs2, w1, w2, p1, p2, b1, b2, d1, d2;
    logic [8:0]  x1, x2;
    logic [7:0]  y1, y2;
    logic [39:0] outs1, outs2;
    assign outs1 = {a1, cs1, w1, c1, x1, y1, p1, b1, d1};
    assign outs2 = {a2, cs2, w2, c2, x2, y2, p2, b2, d2};

    canvas_scanout #(.RAM_LATENCY(1)) u_dut1 (
        .iClk(clk), .iResetn(rst_n), .iStart(st1), .iSlot(slot_in), .iQ(q1),
        .oAddress(a1), .oChipSelect(cs1), .oWren(w1), .oColour(c1),
        .oX_pixel(x1), .oY_pixel(y1), .oPlot(p1), .oBusy(b1), .oDone(d1));

    canvas_scanout #(.RAM_LATENCY(2)) u_dut2 (
        .iClk(clk), .iResetn(rst_n), .iStart(st2), .iSlot(slot_in), .iQ(q2),
        .oAddress(a2), .oChipSelect(cs2), .oWren(w2), .oColour(c2),
        .oX_pixel(x2), .oY_pixel(y2), .oPlot(p2), .oBusy(b2), .oDone(d2));

    // Memory model: one registered read stage for dut1, two for dut2.
    logic [2:0] mem [0:2047];
    logic [2:0] m1_s1 = '0, m2_s1 = '0, m2_s2 = '0;
    always @(posedge clk) begin
        if (cs1) m1_s1 <= mem[a1[10:0]];
        if (cs2) m2_s1 <= mem[a2[10:0]];
        m2_s2 <= m2_s1;
    end
    assign q1 = m1_s1;
    assign q2 = m2_s2;

    function automatic logic [2:0] exp_col(input logic slot, input int cx, input int cy);
        int idx;
        idx = cy * 32 + cx;
`ifdef SCANOUT_SKIP_BLANK_EN
        return (!slot && cx == 31 && cy == 23) ? 3'd5 : 3'd0;
`else
        return slot ? 3'((1024 + idx + 3) % 8) : 3'(idx % 8);
`endif
    endfunction

    typedef struct {
        int   sel;
        logic slot;
        bit   extra;
        int   cycles;
        int   plots;
        int   reqs;
        int   first;
        int   last;
        int   px;
        int   py;
        int   pcol;
        int   xmin;
        int   xmax;
        int   ymin;
        int   ymax;
    } vec_t;

    vec_t vecs [0:2];
    int   nvec;

    int checks = 0, errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard state, written by the monitor and cleared per run.
    bit   mon_on = 1'b0;
    int   sel = 0;
    logic cur_slot = 1'b0;
    int   probe_x, probe_y, probe_c;
    int   plots, distinct, col_errs, oob, reqs, dones, wren_errs;
    int   first_a, last_a, amin, amax, xmin, xmax, ymin, ymax;
    bit   seen [0:159][0:119];

    logic        mp, mcs, mw, md;
    logic [8:0]  mx;
    logic [7:0]  my;
    logic [2:0]  mc;
    logic [14:0] ma;

    always @(negedge clk) begin
        if (mon_on) begin
            if (sel == 0) {mp, mx, my, mc, mcs, ma, md, mw} = {p1, x1, y1, c1, cs1, a1, d1, w1};
            else          {mp, mx, my, mc, mcs, ma, md, mw} = {p2, x2, y2, c2, cs2, a2, d2, w2};
            if (mw) wren_errs++;
            if (md) dones++;
            if (mcs) begin
                reqs++;
                if (reqs == 1) first_a = int'(ma);
                last_a = int'(ma);
                if (int'(ma) < amin) amin = int'(ma);
                if (int'(ma) > amax) amax = int'(ma);
            end
            if (mp) begin
                plots++;
                if (int'(mx) < xmin) xmin = int'(mx);
                if (int'(mx) > xmax) xmax = int'(mx);
                if (int'(my) < ymin) ymin = int'(my);
                if (int'(my) > ymax) ymax = int'(my);
                if (mx < 9'd160 && my < 8'd120) begin
                    if (!seen[mx][my]) distinct++;
                    seen[mx][my] = 1'b1;
                    if (mc !== exp_col(cur_slot, int'(mx) / 5, int'(my) / 5)) col_errs++;
                    if (int'(mx) == probe_x && int'(my) == probe_y) probe_c = int'(mc);
                end else begin
                    oob++;
                end
            end
        end
    end

    task automatic set_start(input bit v);
        if (sel == 0) st1 = v;
        else          st2 = v;
    endtask

    task automatic run_vec(input vec_t v);
        bit got, busy, done;
        int cyc, reqs_at_done;
        sel = v.sel; cur_slot = v.slot; probe_x = v.px; probe_y = v.py; probe_c = -1;
        plots = 0; distinct = 0; col_errs = 0; oob = 0; reqs = 0; dones = 0; wren_errs = 0;
        first_a = -1; last_a = -1; amin = 1 << 20; amax = -1;
        xmin = 1000; xmax = -1; ymin = 1000; ymax = -1;
        for (int i = 0; i < 160; i++)
            for (int j = 0; j < 120; j++) seen[i][j] = 1'b0;

        @(negedge clk);
        mon_on = 1'b1; slot_in = v.slot; set_start(1'b1);
        @(posedge clk); #1;
        set_start(1'b0);
        slot_in = ~v.slot;
        cyc = 0; got = 1'b0; busy = 1'b0;
        while (!got && cyc < 30000) begin
            @(posedge clk); cyc++; #1;
            busy = (sel == 0) ? b1 : b2;
            done = (sel == 0) ? d1 : d2;
            if (cyc == 50) check("busy_mid_run", busy, 1);
            if (done) got = 1'b1;
            else set_start(v.extra && (cyc == 100 || cyc == 5000));
        end
        set_start(1'b0);
        check("done_reached", got, 1);
        check("frame_cycles", cyc, v.cycles);
        check("busy_low_in_done", busy, 0);

        // A start pulse sampled in the DONE cycle must not begin a new replay.
        reqs_at_done = reqs;
        set_start(1'b1);
        @(posedge clk); #1;
        set_start(1'b0);
        repeat (6) @(posedge clk);
        #1;
        busy = (sel == 0) ? b1 : b2;
        check("start_in_done_busy", busy, 0);
        check("start_in_done_reqs", reqs - reqs_at_done, 0);
        @(negedge clk);
        mon_on = 1'b0;

        check("plot_count", plots, v.plots);
        check("distinct_pixels", distinct, v.plots);
        check("colour_errors", col_errs, 0);
        check("out_of_range_plots", oob, 0);
        check("req_count", reqs, v.reqs);
        check("first_addr", first_a, v.first);
        check("last_addr", last_a, v.last);
        check("min_addr", amin, v.first);
        check("max_addr", amax, v.last);
        check("x_min", xmin, v.xmin);
        check("x_max", xmax, v.xmax);
        check("y_min", ymin, v.ymin);
        check("y_max", ymax, v.ymax);
        check("probe_colour", probe_c, v.pcol);
        check("done_pulses", dones, 1);
        check("wren_high", wren_errs, 0);
        check("x_hold", (sel == 0) ? x1 : x2, 159);
        check("y_hold", (sel == 0) ? y1 : y2, 119);
    endtask

    task automatic reset_mid_draw();
        int n_done, n_cs;
        @(negedge clk);
        slot_in = 1'b1; st1 = 1'b1;
        @(posedge clk); #1;
        st1 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("pre_reset_plot_busy", {p1, b1}, 2'b11);
        rst_n = 1'b0;
        #1;
        check("reset_async_outs", outs1, 0);
        @(posedge clk); #1;
        check("reset_next_edge_outs", outs1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0; n_cs = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (d1) n_done++;
            if (cs1) n_cs++;
        end
        check("post_reset_busy", b1, 0);
        check("post_reset_done", n_done, 0);
        check("post_reset_reqs", n_cs, 0);
    endtask

    initial begin
        for (int a = 0; a < 2048; a++)
            mem[a] = exp_col(a[10], (a % 1024) % 32, (a % 1024) / 32);

        // Last cell (31,23) sits at index 23*32+31 = 0x2FF within its slot.
`ifdef SCANOUT_SKIP_BLANK_EN
        nvec = 2;
        vecs[0] = '{0, 1'b0, 1'b1, 2329, 25, 768, 'h000, 'h2FF, 157, 117, 5, 155, 159, 115, 119};
        vecs[1] = '{1, 1'b0, 1'b0, 3097, 25, 768, 'h000, 'h2FF, 155, 119, 5, 155, 159, 115, 119};
        vecs[2] = vecs[1];
`else
        nvec = 3;
        vecs[0] = '{0, 1'b0, 1'b0, 21504, 19200, 768, 'h000, 'h2FF, 7, 3, 1, 0, 159, 0, 119};
        vecs[1] = '{0, 1'b1, 1'b1, 21504, 19200, 768, 'h400, 'h6FF, 7, 3, 4, 0, 159, 0, 119};
        vecs[2] = '{1, 1'b0, 1'b0, 22272, 19200, 768, 'h000, 'h2FF, 13, 9, 2, 0, 159, 0, 119};
`endif

        repeat (2) @(negedge clk);
        check("reset_outs_dut1", outs1, 0);
        check("reset_outs_dut2", outs2, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        reset_mid_draw();
        for (int i = 0; i < nvec; i++) run_vec(vecs[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
